// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: sequences wordline, bitline and pulse timing for single-word
// reads/writes to a ROWS x DATA_W 6T cell array and checks read sense complementarity.
module sram_rw_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int ROWS      = 16,
  parameter int DATA_W    = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ROWS-1:0]   wl,
  output logic [DATA_W-1:0] bl1_drv,
  output logic [DATA_W-1:0] bl2_drv,
  output logic              write_pulse,
  output logic              read_pulse,
  input  logic [DATA_W-1:0] bl1_sense,
  input  logic [DATA_W-1:0] bl2_sense
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SAMPLE, RECOVER} state_t;
  localparam int CW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYC - 1);
  state_t        r_state;
  logic          r_we;
  logic          r_bad;
  logic [CW-1:0] r_cnt;
  logic            w_bad;
  logic [ROWS-1:0] w_onehot;
  logic            w_sense_err;
  assign w_bad    = {1'b0, req_addr} >= (ADDR_W+1)'(ROWS);
  assign w_onehot = w_bad ? '0 : ROWS'(1) << req_addr;
  // Every bit must read as a clean complementary pair; unknowns fail the compare too.
  assign w_sense_err = (&(bl1_sense ^ bl2_sense)) !== 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_cnt       <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      wl          <= '0;
      bl1_drv     <= '1;
      bl2_drv     <= '1;
      write_pulse <= 1'b0;
      read_pulse  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid && req_ready) begin
          r_state   <= SETUP;
          req_ready <= 1'b0;
          r_we      <= req_we;
          r_bad     <= w_bad;
          wl        <= w_onehot;
          bl1_drv   <= req_we ? req_wdata : '1;
          bl2_drv   <= req_we ? ~req_wdata : '1;
        end
        SETUP: begin
          r_state     <= PULSE;
          r_cnt       <= '0;
          write_pulse <= r_we;
          read_pulse  <= !r_we;
        end
        PULSE: if (r_cnt == LAST) begin
          r_state     <= SAMPLE;
          write_pulse <= 1'b0;
          read_pulse  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        SAMPLE: begin
          r_state    <= RECOVER;
          wl         <= '0;
          bl1_drv    <= '1;
          bl2_drv    <= '1;
          resp_valid <= 1'b1;
          resp_rdata <= (r_we || r_bad) ? '0 : bl1_sense;
          resp_err   <= r_bad || (!r_we && w_sense_err);
        end
        RECOVER: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb_sram_rw_ctrl: drives sram_rw_ctrl (12 populated rows) against a behavioural
// cell array, scoreboarding responses and watching pulse/wordline invariants.
module tb_sram_rw_ctrl;
  localparam int PC = 2;
  logic        clk = 0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic [11:0] wl;
  logic [7:0]  bl1_drv, bl2_drv, bl1_sense, bl2_sense;
  logic        write_pulse, read_pulse;
  logic        force_b0 = 0;
  logic        cell_clr = 1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {logic [7:0] d; logic e; int c;} exp_t;
  exp_t q[$];
  logic [7:0] mem [12];
  logic [7:0] ref_mem [12];
  logic       prev_rv = 0;
  int         acc_cyc [8];

  sram_rw_ctrl #(.ADDR_W(4), .ROWS(12), .DATA_W(8), .PULSE_CYC(PC)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wl(wl), .bl1_drv(bl1_drv), .bl2_drv(bl2_drv),
    .write_pulse(write_pulse), .read_pulse(read_pulse),
    .bl1_sense(bl1_sense), .bl2_sense(bl2_sense));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    for (int r = 0; r < 12; r++)
      if (cell_clr) mem[r] <= '0;
      else if (write_pulse && wl[r]) mem[r] <= bl1_drv;

  always_comb begin
    bl1_sense = '1;
    bl2_sense = '1;
    for (int r = 0; r < 12; r++)
      if (wl[r]) begin
        bl1_sense = mem[r];
        bl2_sense = ~mem[r];
      end
    if (force_b0) begin
      bl1_sense[0] = 1'b1;
      bl2_sense[0] = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic bad;
    cyc++;
    if (cell_clr) for (int r = 0; r < 12; r++) ref_mem[r] = '0;
    chk("wl_onehot0", 32'($onehot0(wl)), 1);
    chk("pulse_excl", 32'(write_pulse & read_pulse), 0);
    chk("rv_single", 32'(resp_valid & prev_rv), 0);
    prev_rv = resp_valid;
    if (!rst_n) q.delete();
    else begin
      if (resp_valid) begin
        if (q.size() == 0) chk("resp_unexp", 1, 0);
        else begin
          e = q.pop_front();
          chk("rdata", 32'(resp_rdata), 32'(e.d));
          chk("err", 32'(resp_err), 32'(e.e));
          chk("latency", cyc, e.c);
        end
      end
      if (req_valid && req_ready) begin
        bad = req_addr >= 4'd12;
        e.d = (req_we || bad) ? 8'h00 : (ref_mem[req_addr] | {7'b0, force_b0});
        e.e = bad || (!req_we && force_b0);
        e.c = cyc + PC + 3;
        q.push_back(e);
        if (req_we && !bad) ref_mem[req_addr] = req_wdata;
      end
    end
  end

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    chk("accept_timeout", 32'(n >= 50), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    #12;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_wl", 32'(wl), 0);
    chk("rst_bl1", 32'(bl1_drv), 32'hFF);
    chk("rst_bl2", 32'(bl2_drv), 32'hFF);
    chk("rst_pulses", 32'({write_pulse, read_pulse}), 0);
    chk("rst_resp", 32'({resp_valid, resp_err, resp_rdata}), 0);
    @(posedge clk); #1;
    cell_clr = 0;
    rst_n = 1;
    @(posedge clk); #1;

    send(1, 3, 8'hA5);
    req_valid = 0;
    chk("setup_wl", 32'(wl), 32'h008);
    chk("setup_bl1", 32'(bl1_drv), 32'hA5);
    chk("setup_bl2", 32'(bl2_drv), 32'h5A);
    chk("setup_wp", 32'(write_pulse), 0);
    chk("busy_ready", 32'(req_ready), 0);
    for (int i = 0; i < PC; i++) begin
      @(posedge clk); #1;
      chk("pulse_wp", 32'({write_pulse, read_pulse}), 32'b10);
      chk("pulse_wl", 32'(wl), 32'h008);
      chk("pulse_bl", 32'({bl1_drv, bl2_drv}), 32'hA55A);
    end
    @(posedge clk); #1;
    chk("sample_wp", 32'(write_pulse), 0);
    chk("sample_wl", 32'(wl), 32'h008);
    @(posedge clk); #1;
    chk("recover_wl", 32'(wl), 0);
    chk("recover_bl", 32'({bl1_drv, bl2_drv}), 32'hFFFF);
    chk("recover_rv", 32'(resp_valid), 1);
    @(posedge clk); #1;
    chk("idle_ready", 32'(req_ready), 1);
    send(0, 3, 8'h00);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(i < 4, 4'(i % 4), 8'((i % 4 + 1) * 8'h11));
      acc_cyc[i] = cyc;
      chk("b2b_busy", 32'(req_ready), 0);
    end
    for (int i = 1; i < 8; i++) chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], PC + 4);
    drain();

    force_b0 = 1;
    send(0, 1, 8'h00);
    drain();
    force_b0 = 0;

    send(0, 13, 8'h00);
    req_valid = 0;
    for (int i = 0; i < PC + 3; i++) begin
      chk("bad_wl", 32'(wl), 0);
      if (i == 1) chk("bad_rp", 32'(read_pulse), 1);
      @(posedge clk); #1;
    end
    drain();
    send(1, 12, 8'hEE);
    send(0, 11, 8'h00);
    drain();

    send(1, 5, 8'h3C);
    drain();
    send(1, 5, 8'h3C);
    req_valid = 0;
    @(posedge clk); #1;
    chk("mid_wp", 32'(write_pulse), 1);
    rst_n = 0;
    #1;
    chk("async_wl", 32'(wl), 0);
    chk("async_pulses", 32'({write_pulse, read_pulse}), 0);
    chk("async_ready", 32'(req_ready), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    send(0, 5, 8'h00);
    drain();

    for (int i = 0; i < 24; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
